// File: rtl/id_inst_queue.sv
// id_inst_queue: DEPTH-entry FIFO between fetch and decode.
// Holds fetched bundles (inst, pc, pc_old, pc_pred), supports a
// redirect flush and reports occupancy. Outputs come from registered
// state only; there is no same-cycle bypass from fetch to decode.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where the producer's req and the consumer's ack are both high.
// o_fetched_ack depends only on the queue being not full, and
// o_decoded_req depends only on the queue being not empty, so neither
// ack is a function of the opposite side's inputs. The producer must
// hold req and payload stable until it sees ack. A transfer attempted in
// a cycle with i_flush high is dropped.
module id_inst_queue #(
   parameter int DEPTH  = 4,
   parameter int INST_W = 32,
   parameter int PC_W   = 64,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_fetched_req,
   output logic              o_fetched_ack,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [INST_W-1:0] i_inst,
   input  logic [PC_W-1:0]   i_pc_old,
   input  logic [PC_W-1:0]   i_pc_pred,
   input  logic              i_flush,
   output logic              o_decoded_req,
   input  logic              i_decoded_ack,
   output logic [PC_W-1:0]   o_pc,
   output logic [INST_W-1:0] o_inst,
   output logic [PC_W-1:0]   o_pc_old,
   output logic [PC_W-1:0]   o_pc_pred,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointers carry one extra wrap bit so full and empty are distinct.
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;

   // Payload storage; contents are don't-care until written.
   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PC_W-1:0]   old_mem  [DEPTH];
   logic [PC_W-1:0]   pred_mem [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign rd_idx = rd_ptr[IDX_W-1:0];
   assign wr_idx = wr_ptr[IDX_W-1:0];

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_idx == wr_idx) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

   // A flush wins over both transfers in the same cycle.
   assign push = i_fetched_req & ~full & ~i_flush;
   assign pop  = ~empty & i_decoded_ack & ~i_flush;

   // Pointer update: flush empties the queue by catching rd up to wr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (i_flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Storage write at the write index on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_idx]   <= i_pc;
         inst_mem[wr_idx] <= i_inst;
         old_mem[wr_idx]  <= i_pc_old;
         pred_mem[wr_idx] <= i_pc_pred;
      end
   end

   // Status and handshake outputs, all from registered pointers.
   assign o_fetched_ack = ~full;
   assign o_decoded_req = ~empty;
   assign o_full        = full;
   assign o_empty       = empty;
   assign o_count       = CNT_W'(wr_ptr - rd_ptr);

   // Head payload, forced to zero while the queue is idle.
   assign o_pc      = empty ? '0 : pc_mem[rd_idx];
   assign o_inst    = empty ? '0 : inst_mem[rd_idx];
   assign o_pc_old  = empty ? '0 : old_mem[rd_idx];
   assign o_pc_pred = empty ? '0 : pred_mem[rd_idx];

endmodule

// File: tb/tb_id_inst_queue.sv
// Testbench for id_inst_queue: directed scenarios plus a randomized run,
// checked against a queue-based reference model of the fetch/decode FIFO.
module tb_id_inst_queue;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int PC_W   = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BW     = 3 * PC_W + INST_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              i_fetched_req;
  logic              o_fetched_ack;
  logic [PC_W-1:0]   i_pc;
  logic [INST_W-1:0] i_inst;
  logic [PC_W-1:0]   i_pc_old;
  logic [PC_W-1:0]   i_pc_pred;
  logic              i_flush;
  logic              o_decoded_req;
  logic              i_decoded_ack;
  logic [PC_W-1:0]   o_pc;
  logic [INST_W-1:0] o_inst;
  logic [PC_W-1:0]   o_pc_old;
  logic [PC_W-1:0]   o_pc_pred;
  logic [CNT_W-1:0]  o_count;
  logic              o_full;
  logic              o_empty;

  id_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .i_fetched_req(i_fetched_req), .o_fetched_ack(o_fetched_ack),
    .i_pc(i_pc), .i_inst(i_inst), .i_pc_old(i_pc_old), .i_pc_pred(i_pc_pred),
    .i_flush(i_flush),
    .o_decoded_req(o_decoded_req), .i_decoded_ack(i_decoded_ack),
    .o_pc(o_pc), .o_inst(o_inst), .o_pc_old(o_pc_old), .o_pc_pred(o_pc_pred),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected queue contents, head at index 0.
  logic [BW-1:0] exp_q[$];

  function automatic logic [BW-1:0] exp_head();
    if (exp_q.size() == 0) return '0;
    return exp_q[0];
  endfunction

  function automatic logic [BW-1:0] obs_head();
    return {o_pc, o_inst, o_pc_old, o_pc_pred};
  endfunction

  // Driver tasks
  task automatic set_bundle(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst);
    i_pc      = pc;
    i_inst    = inst;
    i_pc_old  = pc - 64'd4;
    i_pc_pred = pc + 64'd4;
  endtask

  task automatic idle_inputs();
    i_fetched_req = 1'b0;
    i_decoded_ack = 1'b0;
    i_flush       = 1'b0;
    set_bundle('0, '0);
  endtask

  // One clock edge; the model applies the FIFO rules to the inputs seen at the edge.
  task automatic cycle();
    bit full_m = (exp_q.size() == DEPTH);
    bit push_m = i_fetched_req && !full_m && !i_flush;
    bit pop_m  = (exp_q.size() != 0) && i_decoded_ack && !i_flush;
    logic [BW-1:0] b = {i_pc, i_inst, i_pc_old, i_pc_pred};
    @(posedge clk);
    if (i_flush) exp_q.delete();
    else begin
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) cycle();
    checks++;
    if (o_empty !== 1'b1 || o_fetched_ack !== 1'b1 || o_decoded_req !== 1'b0 ||
        o_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b ack=%b req=%b full=%b, want 1 1 0 0",
               o_empty, o_fetched_ack, o_decoded_req, o_full);
    end
    checks++;
    if (o_inst !== '0 || o_pc !== '0 || o_count !== '0) begin
      errors++;
      $display("FAIL reset_payload: inst=%h pc=%h count=%0d, want 0 0 0", o_inst, o_pc, o_count);
    end
  endtask

  task automatic test_single();
    i_fetched_req = 1'b1;
    set_bundle(64'h8000_0000, 32'h0000_0513);
    #1;
    checks++;
    if (o_decoded_req !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: req=%b, want 0", o_decoded_req);
    end
    cycle();
    i_fetched_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_decoded_req !== 1'b1 || o_pc !== 64'h8000_0000 || o_inst !== 32'h0000_0513 ||
          o_count !== 3'd1 || o_pc_old !== 64'h7FFF_FFFC || o_pc_pred !== 64'h8000_0004) begin
        errors++;
        $display("FAIL single_hold[%0d]: req=%b pc=%h inst=%h count=%0d, want 1 80000000 00000513 1",
                 k, o_decoded_req, o_pc, o_inst, o_count);
      end
      cycle();
    end
    i_decoded_ack = 1'b1;
    cycle();
    i_decoded_ack = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_inst !== '0) begin
      errors++;
      $display("FAIL single_pop: empty=%b inst=%h, want 1 0", o_empty, o_inst);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < DEPTH; k++) begin
      i_fetched_req = 1'b1;
      set_bundle(64'h8000_0000 + 64'(4 * k), 32'h0010_0093 + 32'(k));
      cycle();
    end
    set_bundle(64'h8000_0010, 32'hDEAD_BEEF);
    repeat (2) begin
      checks++;
      if (o_full !== 1'b1 || o_fetched_ack !== 1'b0 || o_count !== 3'd4) begin
        errors++;
        $display("FAIL fill_full: full=%b ack=%b count=%0d, want 1 0 4", o_full, o_fetched_ack, o_count);
      end
      cycle();
    end
    // Offer while full with a concurrent pop: the pop happens, the push does not.
    i_decoded_ack = 1'b1;
    cycle();
    i_fetched_req = 1'b0;
    checks++;
    if (o_count !== 3'd3 || o_pc !== 64'h8000_0004) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d pc=%h, want 3 80000004", o_count, o_pc);
    end
    for (int k = 1; k < DEPTH; k++) begin
      checks++;
      if (o_pc !== 64'h8000_0000 + 64'(4 * k) || o_inst !== 32'h0010_0093 + 32'(k)) begin
        errors++;
        $display("FAIL fill_order[%0d]: pc=%h inst=%h, want %h", k, o_pc, o_inst,
                 64'h8000_0000 + 64'(4 * k));
      end
      cycle();
    end
    i_decoded_ack = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_count !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill_drain: empty=%b count=%0d, want 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_stream();
    i_fetched_req = 1'b1;
    set_bundle(64'h9000_0000, 32'h1000_0000);
    cycle();
    i_decoded_ack = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      set_bundle(64'h9000_0000 + 64'(4 * k), 32'h1000_0000 + 32'(k));
      checks++;
      if (o_count !== 3'd1 || o_pc !== 64'h9000_0000 + 64'(4 * (k - 1)) ||
          o_inst !== 32'h1000_0000 + 32'(k - 1)) begin
        errors++;
        $display("FAIL stream[%0d]: count=%0d pc=%h, want 1 %h", k, o_count, o_pc,
                 64'h9000_0000 + 64'(4 * (k - 1)));
      end
      cycle();
    end
    i_fetched_req = 1'b0;
    cycle();
    i_decoded_ack = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_drain: empty=%b, want 1", o_empty);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      i_fetched_req = 1'b1;
      set_bundle(64'hA000_0000 + 64'(4 * k), 32'h2000_0000 + 32'(k));
      cycle();
    end
    set_bundle(64'h8000_0FFC, 32'h3333_3333);
    i_decoded_ack = 1'b1;
    i_flush       = 1'b1;
    #1;
    checks++;
    if (o_fetched_ack !== 1'b1 || o_count !== 3'd3) begin
      errors++;
      $display("FAIL flush_ack: ack=%b count=%0d, want 1 3", o_fetched_ack, o_count);
    end
    cycle();
    i_flush       = 1'b0;
    i_decoded_ack = 1'b0;
    checks++;
    if (o_count !== '0 || o_decoded_req !== 1'b0 || o_pc !== '0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d req=%b pc=%h, want 0 0 0", o_count, o_decoded_req, o_pc);
    end
    set_bundle(64'h8000_1000, 32'h4444_4444);
    cycle();
    i_fetched_req = 1'b0;
    checks++;
    if (o_pc !== 64'h8000_1000 || o_count !== 3'd1 || o_inst !== 32'h4444_4444) begin
      errors++;
      $display("FAIL flush_next: pc=%h count=%0d, want 80001000 1", o_pc, o_count);
    end
    i_decoded_ack = 1'b1;
    cycle();
    i_decoded_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      i_fetched_req = 1'b1;
      set_bundle(64'hB000_0000 + 64'(4 * k), 32'h5000_0000 + 32'(k));
      cycle();
    end
    i_fetched_req = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (o_empty !== 1'b1 || o_inst !== '0 || o_count !== '0 || o_fetched_ack !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: empty=%b inst=%h count=%0d ack=%b, want 1 0 0 1",
               o_empty, o_inst, o_count, o_fetched_ack);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    i_fetched_req = 1'b1;
    set_bundle(64'hC000_0000, 32'h6666_6666);
    cycle();
    i_fetched_req = 1'b0;
    checks++;
    if (o_pc !== 64'hC000_0000 || o_count !== 3'd1 || o_decoded_req !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_push: pc=%h count=%0d req=%b, want c0000000 1 1",
               o_pc, o_count, o_decoded_req);
    end
    i_decoded_ack = 1'b1;
    cycle();
    i_decoded_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      i_fetched_req = ($urandom_range(0, 99) < 60);
      i_decoded_ack = ($urandom_range(0, 99) < 50);
      i_flush       = ($urandom_range(0, 99) < 4);
      i_pc          = {$urandom, $urandom};
      i_inst        = $urandom;
      i_pc_old      = {$urandom, $urandom};
      i_pc_pred     = {$urandom, $urandom};
      #1;
      checks++;
      if (o_count !== CNT_W'(exp_q.size()) || o_empty !== (exp_q.size() == 0) ||
          o_full !== (exp_q.size() == DEPTH) || o_fetched_ack !== (exp_q.size() != DEPTH) ||
          o_decoded_req !== (exp_q.size() != 0) || obs_head() !== exp_head()) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d full=%b empty=%b pc=%h, want count=%0d pc=%h",
                 n, o_count, o_full, o_empty, o_pc, exp_q.size(), exp_head()[BW-1 -: PC_W]);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
